// File: rtl/operand_sequencer.sv
// operand_sequencer: plays a loaded table of (value, dwell) entries as a timed operand stream.
// Each operand is presented with its |~value and !value flags for side-by-side comparison.
module operand_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned DWELL_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_value,
    input  logic [DWELL_W-1:0]       wr_dwell,
    input  logic [$clog2(DEPTH):0]   len,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic                     busy,
    output logic [WIDTH-1:0]         value_o,
    output logic                     tilda_o,
    output logic                     not_o,
    output logic                     step_o,
    output logic                     done_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [0:0] {StIdle, StPlay} state_e;

    state_e             r_state_q, r_state_d;
    logic [AW-1:0]      r_idx_q, r_idx_d;
    logic [DWELL_W-1:0] r_cnt_q, r_cnt_d;
    logic [WIDTH-1:0]   r_value_q, r_value_d;
    logic               r_step_q, r_step_d;
    logic [LW-1:0]      r_len_q, r_len_d;
    logic               r_loop_q, r_loop_d;

    logic [WIDTH-1:0]   r_tbl_value [DEPTH];
    logic [DWELL_W-1:0] r_tbl_dwell [DEPTH];

    logic [LW-1:0]      w_len_eff;
    logic               w_last;
    logic               w_load;
    logic [AW-1:0]      w_load_idx;
    logic               w_done;

    // Table storage; a same-cycle load of the written entry sees the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl_value[i] <= '0;
                r_tbl_dwell[i] <= '0;
            end
        end else if (wr_en) begin
            r_tbl_value[wr_addr] <= wr_value;
            r_tbl_dwell[wr_addr] <= wr_dwell;
        end
    end

    assign w_len_eff = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    assign w_last    = ({1'b0, r_idx_q} == (r_len_q - LW'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= StIdle;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_value_q <= '0;
            r_step_q  <= 1'b0;
            r_len_q   <= '0;
            r_loop_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_value_q <= r_value_d;
            r_step_q  <= r_step_d;
            r_len_q   <= r_len_d;
            r_loop_q  <= r_loop_d;
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_idx_d    = r_idx_q;
        r_cnt_d    = r_cnt_q;
        r_value_d  = r_value_q;
        r_step_d   = 1'b0;
        r_len_d    = r_len_q;
        r_loop_d   = r_loop_q;
        w_load     = 1'b0;
        w_load_idx = '0;
        w_done     = 1'b0;

        unique case (r_state_q)
            StIdle: begin
                if (start && (w_len_eff != '0)) begin
                    r_state_d  = StPlay;
                    r_len_d    = w_len_eff;
                    r_loop_d   = loop;
                    w_load     = 1'b1;
                    w_load_idx = '0;
                end
            end
            StPlay: begin
                // stop wins over any advance or completion in the same cycle
                if (stop) begin
                    r_state_d = StIdle;
                end else if (r_cnt_q != '0) begin
                    r_cnt_d = r_cnt_q - DWELL_W'(1);
                end else if (!w_last) begin
                    w_load     = 1'b1;
                    w_load_idx = r_idx_q + AW'(1);
                end else if (r_loop_q) begin
                    w_load     = 1'b1;
                    w_load_idx = '0;
                end else begin
                    r_state_d = StIdle;
                    w_done    = 1'b1;
                end
            end
            default: r_state_d = StIdle;
        endcase

        if (w_load) begin
            r_idx_d   = w_load_idx;
            r_value_d = r_tbl_value[w_load_idx];
            r_cnt_d   = r_tbl_dwell[w_load_idx];
            r_step_d  = 1'b1;
        end
    end

    assign busy    = (r_state_q == StPlay);
    assign value_o = r_value_q;
    assign tilda_o = |(~r_value_q);
    assign not_o   = ~(|r_value_q);
    assign step_o  = r_step_q;
    assign done_o  = w_done;

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Synthesizable stimulus source for the simulation examples.
- A small table of (value, dwell) entries is loaded over a write port, then played out as a timed operand stream.
- Each played operand comes with its bitwise-complement truthiness (|~value) and its logical-NOT result (!value), so downstream observers can compare the two directly.

Parameters:
- WIDTH, 8, operand width in bits.
- DEPTH, 8, number of table entries (power of two, ≥2).
- DWELL_W, 8, width of the per-entry dwell count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  $clog2(DEPTH)  entry index to write.
- wr_value  in  WIDTH  operand value to store.
- wr_dwell  in  DWELL_W  hold count to store; the entry is held for wr_dwell+1 cycles.
- len  in  $clog2(DEPTH)+1  number of entries to play; sampled at start.
- start  in  1  begin playback, single-cycle pulse.
- stop  in  1  abort playback.
- loop  in  1  wrap to entry 0 after the last entry; sampled at start.
- busy  out  1  playback active.
- value_o  out  WIDTH  current operand.
- tilda_o  out  1  |(~value_o).
- not_o  out  1  !value_o.
- step_o  out  1  one-cycle pulse on the cycle a new entry appears on value_o.
- done_o  out  1  one-cycle pulse when a non-loop playback completes.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - Table entries all 0; value_o=0, tilda_o=1, not_o=1.
  - busy=0, step_o=0, done_o=0; FSM in IDLE; index and dwell counter 0.
- Derived flags: tilda_o and not_o are combinational from the value_o register, with no extra latency.
- FSM IDLE:
  - start=1 with len≠0 → PLAY.
  - On the next edge: value_o=table[0], dwell counter=dwell[0], index=0, step_o=1, busy=1.
  - Latency start→value_o is 1 cycle.
- len clamping: len>DEPTH is clamped to DEPTH. len==0 means start is ignored: no busy, no done_o.
- FSM PLAY:
  - Counter ≠0: decrement it.
  - Counter ==0 and index<len−1: load the next entry and pulse step_o.
  - Counter ==0 and index==len−1, loop=1: load entry 0, pulse step_o, remain busy.
  - Counter ==0 and index==len−1, loop=0: → IDLE, busy=0, done_o=1 on that cycle. value_o keeps the last entry.
  - Net effect: every entry is visible for exactly dwell+1 cycles.
- start while busy: ignored.
- stop while busy:
  - → IDLE on the next edge; busy=0, no done_o, value_o holds its current value.
  - stop has priority over a simultaneous entry advance or completion.
- stop in IDLE: no effect.
- Table writes:
  - Accepted in any state.
  - A write to the entry currently on display does not change value_o. The new data is used the next time that entry is loaded.
  - A write and a load of the same entry in the same cycle: the load takes the old data.
- Mid-operation reset: asynchronous assertion returns everything, including table contents, to reset values immediately.

Test Plan:
- Reset, then idle → value_o=0, tilda_o=1, not_o=1, busy=0.
- Load 42/1/255/0/3, each with dwell=9; len=5, loop=0; pulse start → required outputs:
  - value_o shows 42, 1, 255, 0, 3 for 10 cycles each, with step_o at cycles 1, 11, 21, 31, 41.
  - tilda_o sequence 1,1,0,1,1; not_o sequence 0,0,0,1,0.
  - done_o pulse at cycle 50; busy=0 afterwards; value_o stays 3.
- Same table with loop=1 → after 3 (cycles 41–50), value_o=42 again at cycle 51 with step_o; done_o never pulses. Assert stop at cycle 57 → busy=0 at 58, value_o holds 42.
- Dwell=0 for all entries, len=3 → a new value every cycle, step_o high on 3 consecutive cycles, done_o on the third cycle.
- len=0, start → no busy, no step_o. len=12 with DEPTH=8 → exactly 8 entries played.
- Write entry 1 to value 7 while entry 1 is displayed → value_o unchanged; with loop=1, the next pass shows 7 (tilda_o=1, not_o=0). Drop rst_n mid-play → outputs return to reset values immediately.
